// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter and LLU scoreboard for the 32x32 register file.
// Define RFWB_STARVE_GUARD_EN to let a starved LLU completion preempt the pipeline.
module regfile_wb_scheduler #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int MAX_WAIT        = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pipeWbValid,
   input  logic [4:0]  pipeWbAddr,
   input  logic [31:0] pipeWbData,
   output logic        pipeStall,
   input  logic        issueValid,
   input  logic [4:0]  issueAddr,
   output logic        issueReady,
   input  logic        lluValid,
   input  logic [4:0]  lluAddr,
   input  logic [31:0] lluData,
   output logic        lluReady,
   input  logic        decodeValid,
   input  logic [4:0]  decodeRs1,
   input  logic [4:0]  decodeRs2,
   input  logic [4:0]  decodeRd,
   output logic        hazardStall,
   output logic        rfWriteEnable,
   output logic [4:0]  rfWriteAddress,
   output logic [31:0] rfWriteData
);

   localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OCW-1:0] OC_MAX = OCW'(MAX_OUTSTANDING);

   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 31 || MAX_WAIT < 1) begin : g_param_err
      $error("regfile_wb_scheduler: parameter out of range");
   end

   logic [31:0]    pending_q, pending_d;
   logic [OCW-1:0] outCount_q, outCount_d;
   logic           pipeUse, forceLlu, issueAcc, lluAcc;

   assign pipeUse = pipeWbValid && (pipeWbAddr != 5'd0);

`ifdef RFWB_STARVE_GUARD_EN
   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

   logic [WCW-1:0] waitCount_q, waitCount_d;

   assign forceLlu = lluValid && (waitCount_q == WAIT_MAX);

   always_comb begin
      waitCount_d = '0;
      if (lluValid && !lluReady) begin
         waitCount_d = (waitCount_q == WAIT_MAX) ? waitCount_q
                                                 : waitCount_q + WCW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) waitCount_q <= '0;
      else       waitCount_q <= waitCount_d;
   end
`else
   assign forceLlu = 1'b0;
`endif

   // Reset gates every handshake so nothing is accepted while state is held clear.
   assign lluReady    = !reset && lluValid && (!pipeUse || forceLlu);
   assign pipeStall   = !reset && forceLlu && pipeUse;
   assign issueReady  = !reset && !pending_q[issueAddr] && (outCount_q < OC_MAX);
   assign hazardStall = !reset && decodeValid &&
                        (pending_q[decodeRs1] || pending_q[decodeRs2] ||
                         pending_q[decodeRd]);

   always_comb begin
      rfWriteEnable  = 1'b0;
      rfWriteAddress = 5'd0;
      rfWriteData    = 32'd0;
      if (lluReady) begin
         rfWriteEnable  = lluAddr != 5'd0;
         rfWriteAddress = lluAddr;
         rfWriteData    = lluData;
      end else if (pipeUse && !reset) begin
         rfWriteEnable  = 1'b1;
         rfWriteAddress = pipeWbAddr;
         rfWriteData    = pipeWbData;
      end
   end

   assign issueAcc = issueValid && issueReady && (issueAddr != 5'd0);
   assign lluAcc   = lluValid && lluReady && (lluAddr != 5'd0);

   always_comb begin
      pending_d  = pending_q;
      outCount_d = outCount_q;
      if (lluAcc)   pending_d[lluAddr]   = 1'b0;
      if (issueAcc) pending_d[issueAddr] = 1'b1;
      pending_d[0] = 1'b0;
      if (issueAcc && !lluAcc)      outCount_d = outCount_q + OCW'(1);
      else if (!issueAcc && lluAcc) outCount_d = outCount_q - OCW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_q  <= '0;
         outCount_q <= '0;
      end else begin
         pending_q  <= pending_d;
         outCount_q <= outCount_d;
      end
   end

endmodule
